// File: rtl/axi_lite_fpro_bridge.sv
// axi_lite_fpro_bridge
//   Converts AXI4-Lite slave transactions into single-cycle FPro bus strobes
//   for the MMIO controller / video mux, and captures their combinational
//   read data. One transaction in flight at a time.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*     : AXI4-Lite write address / data / response
//   s_axi_ar*/r*        : AXI4-Lite read address / data
//   fp_mmio_cs/video_cs : region selects (addr[23] picks video)
//   fp_wr, fp_rd        : one-cycle strobes
//   fp_addr             : word address, byte addr[22:2]
//   fp_wr_data          : write data
//   fp_rd_data          : combinational read data from the slots
//
// Optional build macro
//   FPRO_BRIDGE_ADDR_CHECK_EN : addresses outside BASE_ADDR's 2**REGION_BITS
//   window get no strobe and a DECERR response with zero read data.
module axi_lite_fpro_bridge #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hC000_0000,
  parameter int                REGION_BITS = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              fp_mmio_cs,
  output logic              fp_video_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [20:0]       fp_addr,
  output logic [31:0]       fp_wr_data,
  input  logic [31:0]       fp_rd_data
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WRESP, RRESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              region_ok;
  logic              wr_req;
  logic              wr_ok;

`ifdef FPRO_BRIDGE_ADDR_CHECK_EN
  assign region_ok = ((addr_q ^ BASE_ADDR) >> REGION_BITS) == '0;
`else
  assign region_ok = 1'b1;
`endif

  // Bits that only matter in some builds (byte offset, upper address bits).
  logic unused_ok;
  assign unused_ok = ^{addr_q[1:0], addr_q[ADDR_W-1:24], BASE_ADDR, REGION_BITS != 0};

  // AW and W are only ever taken together.
  assign wr_req = s_axi_awvalid && s_axi_wvalid;
  // Partial writes are refused rather than read-modify-written: the slots
  // have no byte enables.
  assign wr_ok  = region_ok && (wstrb_q == 4'hF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    bresp_d       = bresp_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    fp_wr         = 1'b0;
    fp_rd         = 1'b0;
    fp_mmio_cs    = 1'b0;
    fp_video_cs   = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_awready = wr_req;
        s_axi_wready  = wr_req;
        // Write has priority; a concurrent read waits in IDLE.
        s_axi_arready = s_axi_arvalid && !wr_req;
        if (wr_req) begin
          addr_d  = s_axi_awaddr;
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
          state_d = WRITE;
        end else if (s_axi_arvalid) begin
          addr_d  = s_axi_araddr;
          state_d = READ;
        end
      end
      WRITE: begin
        if (wr_ok) begin
          fp_wr       = 1'b1;
          fp_video_cs = addr_q[23];
          fp_mmio_cs  = !addr_q[23];
        end
        if (!region_ok)              bresp_d = RESP_DECERR;
        else if (wstrb_q != 4'hF)    bresp_d = RESP_SLVERR;
        else                         bresp_d = RESP_OKAY;
        state_d = WRESP;
      end
      READ: begin
        if (region_ok) begin
          fp_rd       = 1'b1;
          fp_video_cs = addr_q[23];
          fp_mmio_cs  = !addr_q[23];
        end
        // Slot data is only valid while the strobe is up, so sample now.
        rdata_d = region_ok ? fp_rd_data : 32'h0;
        rresp_d = region_ok ? RESP_OKAY : RESP_DECERR;
        state_d = RRESP;
      end
      WRESP: if (s_axi_bready) state_d = IDLE;
      RRESP: if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_axi_bvalid = (state_q == WRESP);
  assign s_axi_rvalid = (state_q == RRESP);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign fp_addr      = addr_q[22:2];
  assign fp_wr_data   = wdata_q;

endmodule

// File: doc/axi_lite_fpro_bridge.md
Name: axi_lite_fpro_bridge

Overview:
- Bus bridge that sits directly upstream of the MMIO controller and its slot cores (timer, GPIO, UART).
- Converts MicroBlaze AXI4-Lite slave transactions into the single-cycle FPro bus strobes (cs/wr/rd/addr/wr_data) that the MMIO controller decodes into slot signals.
- Captures the combinational rd_data returned by the slots.
- One outstanding transaction at a time; AXI backpressure isolates the processor from bus timing.

Parameters:
- ADDR_W, 32, AXI address width.
- BASE_ADDR, 32'hC000_0000, byte base of the FPro region; used only when FPRO_BRIDGE_ADDR_CHECK_EN is defined.
- REGION_BITS, 24, size of the FPro region as log2(bytes).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  ADDR_W  write byte address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address accepted
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data accepted
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  master accepts write response
- s_axi_araddr  in  ADDR_W  read byte address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address accepted
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  master accepts read data
- fp_mmio_cs  out  1  MMIO region select
- fp_video_cs  out  1  video region select
- fp_wr  out  1  write strobe, one cycle
- fp_rd  out  1  read strobe, one cycle
- fp_addr  out  21  word address = byte addr[22:2]
- fp_wr_data  out  32  write data
- fp_rd_data  in  32  combinational read data from the MMIO/video mux

Behaviour:
- Reset: all outputs 0; state IDLE; latched address/data 0. Reset mid-transaction aborts it: no strobe is issued, and bvalid/rvalid drop immediately.
- FSM states: IDLE, WRITE, READ, WRESP, RRESP.
- IDLE, write path: s_axi_awready = s_axi_wready = (awvalid && wvalid), combinational, in the same cycle. AW and W are never accepted separately. On acceptance, latch awaddr/wdata/wstrb and go to WRITE.
- IDLE, read path: s_axi_arready = arvalid && !(awvalid && wvalid). A simultaneous write and read → write wins; the read stays pending. On acceptance, latch araddr and go to READ.
- WRITE, exactly 1 cycle:
  - fp_wr = 1; fp_addr = latched addr[22:2]; fp_wr_data = latched data.
  - fp_video_cs = addr[23]; fp_mmio_cs = !addr[23].
  - If wstrb != 4'hF: no strobe and no cs; bresp = SLVERR (2'b10).
  - Go to WRESP.
- WRESP: bvalid = 1 with bresp held until bready is seen high at a clock edge, then IDLE. bready=1 on the first WRESP cycle → IDLE next cycle.
- READ, exactly 1 cycle: fp_rd = 1 plus cs/addr as above. fp_rd_data is registered into s_axi_rdata at the end of that cycle; rresp = OKAY. Go to RRESP.
- RRESP: rvalid = 1 with rdata held stable until rready, then IDLE.
- Strobe rule: fp_rd/fp_wr are never asserted for more than one cycle per transaction, because slot reads may have side effects (FIFO pop).
- Outside WRITE/READ: cs, wr and rd are 0; fp_addr/fp_wr_data hold their last latched values.
- Latency: AW/W handshake → fp_wr at +1 cycle → bvalid at +2. AR handshake → fp_rd at +1 → rvalid at +2.
- Throughput: at best one transaction per 3 cycles.
- Address bits above bit 23 are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: FPRO_BRIDGE_ADDR_CHECK_EN.
- Defined: an address with addr[ADDR_W-1:REGION_BITS] != BASE_ADDR[ADDR_W-1:REGION_BITS] gets no FPro strobe and no cs; the response is DECERR (2'b11) and rdata = 32'h0. The FSM still passes through WRITE/READ with its normal timing.
- Undefined: upper bits are ignored and every address aliases into the region.

Test Plan:
- Write 0xC000_0008, data 0x0000_0003, wstrb F → one cycle of fp_mmio_cs=1, fp_wr=1, fp_addr=21'h000002, fp_wr_data=3; then bvalid with bresp=00.
- Read 0xC000_0004 while fp_rd_data=0x0000_1234 during the READ cycle → fp_rd high exactly 1 cycle with fp_addr=1; rdata=0x0000_1234, rresp=00.
- Simultaneous AW/W and AR valid in IDLE → write completes first; read accepted only after bvalid/bready; exactly one fp_wr and one fp_rd pulse in total.
- Hold bready=0 for 5 cycles → bvalid stays high; awready stays 0 even with new valid requests; no extra strobes.
- Write with wstrb=4'h3 → no fp_wr and no cs; bresp=10. With FPRO_BRIDGE_ADDR_CHECK_EN defined, read 0x4000_0000 → no fp_rd; rresp=11, rdata=0.
- Assert reset during the RRESP state → rvalid=0, state IDLE, all fp outputs 0; the next read completes normally.
